nibbler_sequencer: RTL and testbench

Fetch/decode/execute sequencer for the Nibbler 4-bit CPU; sits directly upstream of the ALU. It owns the program counter, instruction register, accumulator and flag registers. It drives the ALU select, carry-in and both operands. It latches the ALU result and flags back into the accumulator and flag registers at the end of each execute cycle.

---
 rtl/nibbler_pkg.sv | 68 ++++++
 rtl/nibbler_decoder.sv | 54 +++++
 rtl/nibbler_sequencer.sv | 169 ++++++++++++++++
 tb/tb_nibbler_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// Shared types for the Nibbler sequencer: opcodes, FSM states, ALU codes
// and the decoded control bundle.
package nibbler_pkg;

    typedef enum logic [3:0] {
        OP_JC   = 4'h0,
        OP_JNC  = 4'h1,
        OP_JZ   = 4'h2,
        OP_JNZ  = 4'h3,
        OP_JMP  = 4'h4,
        OP_LIT  = 4'h5,
        OP_ADDI = 4'h6,
        OP_CMPI = 4'h7,
        OP_NORI = 4'h8,
        OP_LD   = 4'h9,
        OP_ADD  = 4'hA,
        OP_SUB  = 4'hB,
        OP_NOR  = 4'hC,
        OP_ST   = 4'hD,
        OP_IN   = 4'hE,
        OP_OUT  = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        FETCH2 = 2'd1,
        EXEC   = 2'd2
    } seq_state_t;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_PASS_B = 3'b010;
    localparam logic [2:0] ALU_ADD    = 3'b011;
    localparam logic [2:0] ALU_NOR    = 3'b100;

    typedef enum logic [1:0] {
        B_ZERO = 2'd0,
        B_IMM  = 2'd1,
        B_MEM  = 2'd2,
        B_IN   = 2'd3
    } b_src_t;

    typedef enum logic [2:0] {
        COND_C      = 3'd0,
        COND_NC     = 3'd1,
        COND_Z      = 3'd2,
        COND_NZ     = 3'd3,
        COND_ALWAYS = 3'd4
    } cond_t;

    typedef struct packed {
        logic [2:0] alu_s;
        logic       alu_n_cin;
        b_src_t     b_src;
        logic       acc_we;
        logic       flag_we;
        logic       is_jump;
        cond_t      cond;
        logic       dmem_we;
        logic       out_we;
    } ctrl_t;

    // Jumps and memory-addressed ops carry a second address byte.
    function automatic logic is_two_byte(op_t op);
        return (op <= OP_JMP) || ((op >= OP_LD) && (op <= OP_ST));
    endfunction

endpackage

// File: rtl/nibbler_decoder.sv
// Combinational opcode decoder producing the sequencer control bundle.
module nibbler_decoder
    import nibbler_pkg::*;
(
    input  op_t   op_i,
    output ctrl_t ctrl_o
);

    always_comb begin
        ctrl_o           = '0;
        ctrl_o.alu_s     = ALU_PASS_A;
        ctrl_o.alu_n_cin = 1'b1;
        ctrl_o.b_src     = B_ZERO;
        ctrl_o.cond      = COND_ALWAYS;
        case (op_i)
            OP_JC:   begin ctrl_o.is_jump = 1'b1; ctrl_o.cond = COND_C;  end
            OP_JNC:  begin ctrl_o.is_jump = 1'b1; ctrl_o.cond = COND_NC; end
            OP_JZ:   begin ctrl_o.is_jump = 1'b1; ctrl_o.cond = COND_Z;  end
            OP_JNZ:  begin ctrl_o.is_jump = 1'b1; ctrl_o.cond = COND_NZ; end
            OP_JMP:  ctrl_o.is_jump = 1'b1;
            OP_LIT, OP_LD, OP_IN: begin
                ctrl_o.alu_s   = ALU_PASS_B;
                ctrl_o.acc_we  = 1'b1;
                ctrl_o.flag_we = 1'b1;
                ctrl_o.b_src   = (op_i == OP_LIT) ? B_IMM :
                                 (op_i == OP_LD)  ? B_MEM : B_IN;
            end
            OP_ADDI, OP_ADD: begin
                ctrl_o.alu_s   = ALU_ADD;
                ctrl_o.acc_we  = 1'b1;
                ctrl_o.flag_we = 1'b1;
                ctrl_o.b_src   = (op_i == OP_ADDI) ? B_IMM : B_MEM;
            end
            // CMPI is a SUB that only updates the flags.
            OP_CMPI, OP_SUB: begin
                ctrl_o.alu_s     = ALU_SUB;
                ctrl_o.alu_n_cin = 1'b0;
                ctrl_o.acc_we    = (op_i == OP_SUB);
                ctrl_o.flag_we   = 1'b1;
                ctrl_o.b_src     = (op_i == OP_CMPI) ? B_IMM : B_MEM;
            end
            OP_NORI, OP_NOR: begin
                ctrl_o.alu_s   = ALU_NOR;
                ctrl_o.acc_we  = 1'b1;
                ctrl_o.flag_we = 1'b1;
                ctrl_o.b_src   = (op_i == OP_NORI) ? B_IMM : B_MEM;
            end
            OP_ST:   ctrl_o.dmem_we = 1'b1;
            OP_OUT:  ctrl_o.out_we  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/nibbler_sequencer.sv
// Fetch/decode/execute sequencer for the Nibbler 4-bit CPU; owns PC, IR,
// ACC and flags, drives the external ALU and captures its result in EXEC.
module nibbler_sequencer
    import nibbler_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter int              N        = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            run_i,
    output logic [PC_W-1:0] prog_addr_o,
    input  logic [7:0]      prog_data_i,
    output logic [PC_W-1:0] dmem_addr_o,
    input  logic [N-1:0]    dmem_rdata_i,
    output logic [N-1:0]    dmem_wdata_o,
    output logic            dmem_we_o,
    input  logic [N-1:0]    in_data_i,
    output logic [N-1:0]    out_data_o,
    output logic            out_strobe_o,
    output logic [2:0]      alu_s_o,
    output logic            alu_not_carry_in_o,
    output logic [N-1:0]    alu_a_o,
    output logic [N-1:0]    alu_b_o,
    input  logic [N-1:0]    alu_result_i,
    input  logic            alu_not_c_i,
    input  logic            alu_not_z_i,
    output logic            flag_c_n_o,
    output logic            flag_z_n_o,
    output logic            instr_done_o
);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [7:0]      adrl_q, adrl_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    out_q, out_d;
    logic            fc_n_q, fc_n_d;
    logic            fz_n_q, fz_n_d;

    logic [2:0]      alu_s;
    logic            alu_n_cin;
    logic [N-1:0]    alu_b;
    logic            dmem_we;
    logic            out_strobe;
    logic            instr_done;
    logic            cond_ok;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    ctrl_t           ctrl;

    nibbler_decoder u_decoder (
        .op_i   (op_t'(ir_q[7:4])),
        .ctrl_o (ctrl)
    );

    assign pc_inc = pc_q + PC_W'(1);
    assign target = PC_W'({ir_q[3:0], adrl_q});

    always_comb begin
        cond_ok = 1'b1;
        case (ctrl.cond)
            COND_C:  cond_ok = ~fc_n_q;
            COND_NC: cond_ok = fc_n_q;
            COND_Z:  cond_ok = ~fz_n_q;
            COND_NZ: cond_ok = fz_n_q;
            default: cond_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        adrl_d     = adrl_q;
        acc_d      = acc_q;
        out_d      = out_q;
        fc_n_d     = fc_n_q;
        fz_n_d     = fz_n_q;
        alu_s      = ALU_PASS_A;
        alu_n_cin  = 1'b1;
        alu_b      = '0;
        dmem_we    = 1'b0;
        out_strobe = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                if (run_i) begin
                    ir_d    = prog_data_i;
                    pc_d    = pc_inc;
                    state_d = is_two_byte(op_t'(prog_data_i[7:4])) ? FETCH2 : EXEC;
                end
            end
            FETCH2: begin
                adrl_d  = prog_data_i;
                pc_d    = pc_inc;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                // Strobes are gated by reset so an aborted instruction has no side effect.
                instr_done = ~rst_i;
                dmem_we    = ctrl.dmem_we & ~rst_i;
                out_strobe = ctrl.out_we & ~rst_i;
                if (ctrl.flag_we) begin
                    alu_s     = ctrl.alu_s;
                    alu_n_cin = ctrl.alu_n_cin;
                    case (ctrl.b_src)
                        B_IMM:   alu_b = N'(ir_q[3:0]);
                        B_MEM:   alu_b = dmem_rdata_i;
                        B_IN:    alu_b = in_data_i;
                        default: alu_b = '0;
                    endcase
                    fc_n_d = alu_not_c_i;
                    fz_n_d = alu_not_z_i;
                end
                if (ctrl.acc_we) begin
                    acc_d = alu_result_i;
                end
                if (ctrl.out_we) begin
                    out_d = acc_q;
                end
                if (ctrl.is_jump && cond_ok) begin
                    pc_d = target;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            adrl_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            fc_n_q  <= 1'b1;
            fz_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            adrl_q  <= adrl_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            fc_n_q  <= fc_n_d;
            fz_n_q  <= fz_n_d;
        end
    end

    assign prog_addr_o        = pc_q;
    assign dmem_addr_o        = target;
    assign dmem_wdata_o       = acc_q;
    assign dmem_we_o          = dmem_we;
    assign out_data_o         = out_q;
    assign out_strobe_o       = out_strobe;
    assign alu_s_o            = alu_s;
    assign alu_not_carry_in_o = alu_n_cin;
    assign alu_a_o            = acc_q;
    assign alu_b_o            = alu_b;
    assign flag_c_n_o         = fc_n_q;
    assign flag_z_n_o         = fz_n_q;
    assign instr_done_o       = instr_done;

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Directed bench for nibbler_sequencer with a behavioural ROM, data memory
// and a 4-bit ALU model; expected values are hand-computed per program.
module tb_nibbler_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [11:0] prog_addr;
    logic [7:0]  prog_data;
    logic [11:0] dmem_addr;
    logic [3:0]  dmem_rdata;
    logic [3:0]  dmem_wdata;
    logic        dmem_we;
    logic [3:0]  in_data = 4'h6;
    logic [3:0]  out_data;
    logic        out_strobe;
    logic [2:0]  alu_s;
    logic        alu_ncin;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_result;
    logic        alu_not_c;
    logic        alu_not_z;
    logic        flag_c_n;
    logic        flag_z_n;
    logic        instr_done;

    logic [7:0]  rom [4096];
    logic [3:0]  dmem [4096];
    logic        tb_we = 1'b0;
    logic [11:0] tb_wa = '0;
    logic [3:0]  tb_wd = '0;

    int n_checks = 0;
    int n_errors = 0;
    int we_count;

    always #5 clk = ~clk;

    nibbler_sequencer dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .run_i              (run),
        .prog_addr_o        (prog_addr),
        .prog_data_i        (prog_data),
        .dmem_addr_o        (dmem_addr),
        .dmem_rdata_i       (dmem_rdata),
        .dmem_wdata_o       (dmem_wdata),
        .dmem_we_o          (dmem_we),
        .in_data_i          (in_data),
        .out_data_o         (out_data),
        .out_strobe_o       (out_strobe),
        .alu_s_o            (alu_s),
        .alu_not_carry_in_o (alu_ncin),
        .alu_a_o            (alu_a),
        .alu_b_o            (alu_b),
        .alu_result_i       (alu_result),
        .alu_not_c_i        (alu_not_c),
        .alu_not_z_i        (alu_not_z),
        .flag_c_n_o         (flag_c_n),
        .flag_z_n_o         (flag_z_n),
        .instr_done_o       (instr_done)
    );

    assign prog_data  = rom[prog_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (tb_we)        dmem[tb_wa] <= tb_wd;
        else if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    // ALU model: add/sub with active-low carry-in, carry and zero reported active-low.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = 5'd0;
        case (alu_s)
            3'b010: alu_sum = {1'b0, alu_b};
            3'b011: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, ~alu_ncin};
            3'b001: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, ~alu_ncin};
            3'b100: alu_sum = {1'b0, ~(alu_a | alu_b)};
            default: alu_sum = {1'b0, alu_a};
        endcase
    end
    assign alu_result = alu_sum[3:0];
    assign alu_not_c  = ~alu_sum[4];
    assign alu_not_z  = (alu_sum[3:0] != 4'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h50;
    endtask

    // Leaves the bench mid-cycle 1 (first FETCH at PC 0) with run applied.
    task automatic do_reset(input logic run_after);
        tick();
        rst = 1'b1;
        run = 1'b0;
        tick();
        chk("rst_pc", prog_addr, 12'h000);
        chk("rst_flags", {flag_c_n, flag_z_n}, 2'b11);
        chk("rst_acc", alu_a, 4'h0);
        chk("rst_out", out_data, 4'h0);
        chk("rst_strobes", {dmem_we, out_strobe, instr_done}, 3'b000);
        rst = 1'b0;
        run = run_after;
    endtask

    initial begin
        // Reset during FETCH2 of JMP 0x123 must abort the jump.
        clear_rom();
        rom[0] = 8'h41; rom[1] = 8'h23;
        do_reset(1'b1);
        tick();
        chk("jmp_f2_addr", prog_addr, 12'h001);
        rst = 1'b1;
        tick();
        chk("abort_pc", prog_addr, 12'h000);
        chk("abort_done", instr_done, 1'b0);
        rst = 1'b0;
        run = 1'b0;
        tick(); tick();
        chk("abort_nojump", prog_addr, 12'h000);
        chk("abort_flags", {flag_c_n, flag_z_n}, 2'b11);

        // LIT 9; ADDI 8 -> ACC 1 with carry.
        clear_rom();
        rom[0] = 8'h59; rom[1] = 8'h68;
        do_reset(1'b1);
        chk("add_done_c1", instr_done, 1'b0);
        tick();
        chk("add_done_c2", instr_done, 1'b1);
        chk("lit_alu_s", alu_s, 3'b010);
        chk("lit_alu_b", alu_b, 4'h9);
        tick();
        chk("add_done_c3", instr_done, 1'b0);
        chk("lit_flags", {flag_c_n, flag_z_n}, 2'b11);
        tick();
        chk("add_done_c4", instr_done, 1'b1);
        chk("addi_code", {alu_s, alu_ncin}, 4'b0111);
        tick();
        chk("add_acc", dmem_wdata, 4'h1);
        chk("add_flags", {flag_c_n, flag_z_n}, 2'b01);

        // LIT 0; LIT 5; CMPI 5; JZ 0x0A0 -> jump taken.
        clear_rom();
        rom[0] = 8'h50; rom[1] = 8'h55; rom[2] = 8'h75; rom[3] = 8'h20; rom[4] = 8'hA0;
        do_reset(1'b1);
        for (int i = 1; i < 6; i++) tick();
        chk("cmpi_code", {alu_s, alu_ncin}, 4'b0010);
        tick();
        chk("cmp_acc", alu_a, 4'h5);
        chk("cmp_z", flag_z_n, 1'b0);
        tick(); tick(); tick();
        chk("jz_taken", prog_addr, 12'h0A0);

        // Same with CMPI 4 -> falls through.
        rom[2] = 8'h74;
        do_reset(1'b1);
        for (int i = 1; i < 10; i++) tick();
        chk("jz_fall_pc", prog_addr, 12'h005);
        chk("cmp4_flags", {flag_c_n, flag_z_n}, 2'b01);
        chk("cmp4_acc", alu_a, 4'h5);

        // LIT 0; LIT 3; ST 0x400; LD 0x400; NORI 0xC.
        tb_wa = 12'h400; tb_wd = 4'hA; tb_we = 1'b1;
        tick();
        tb_we = 1'b0;
        clear_rom();
        rom[0] = 8'h50; rom[1] = 8'h53; rom[2] = 8'hD4; rom[3] = 8'h00;
        rom[4] = 8'h94; rom[5] = 8'h00; rom[6] = 8'h8C;
        do_reset(1'b1);
        we_count = 0;
        for (int c = 1; c <= 10; c++) begin
            if (dmem_we) we_count++;
            if (c == 7) begin
                chk("st_we", dmem_we, 1'b1);
                chk("st_addr", dmem_addr, 12'h400);
                chk("st_wdata", dmem_wdata, 4'h3);
            end
            if (c == 10) chk("ld_alu_b", alu_b, 4'h3);
            tick();
        end
        chk("st_pulses", we_count, 1);
        chk("st_mem", dmem[12'h400], 4'h3);
        chk("ld_acc", alu_a, 4'h3);
        tick(); tick();
        chk("nori_acc", alu_a, 4'h0);
        chk("nori_flags", {flag_c_n, flag_z_n}, 2'b10);

        // Reset in EXEC of ST must suppress the write strobe.
        tb_wa = 12'h400; tb_wd = 4'hA; tb_we = 1'b1;
        tick();
        tb_we = 1'b0;
        clear_rom();
        rom[0] = 8'hD4; rom[1] = 8'h00;
        do_reset(1'b1);
        tick(); tick();
        chk("st_exec_we", dmem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("st_rst_we", dmem_we, 1'b0);
        chk("st_rst_done", instr_done, 1'b0);
        tick();
        rst = 1'b0;
        chk("st_rst_mem", dmem[12'h400], 4'hA);

        // JC not taken, JMP 0xFFF, then a JMP split across the wrap.
        clear_rom();
        rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h4F; rom[3] = 8'hFF;
        rom[12'hFFF] = 8'h4F;
        do_reset(1'b1);
        tick(); tick(); tick();
        chk("jc_not_taken", prog_addr, 12'h002);
        tick(); tick(); tick();
        chk("jmp_fff", prog_addr, 12'hFFF);
        tick();
        chk("wrap_pc", prog_addr, 12'h000);
        tick(); tick();
        chk("wrap_target", prog_addr, 12'hF00);

        // run dropped during ADDI EXEC; then OUT and IN.
        clear_rom();
        rom[0] = 8'h52; rom[1] = 8'h63; rom[2] = 8'hF0; rom[3] = 8'hE0;
        do_reset(1'b1);
        tick(); tick(); tick();
        chk("run_exec_done", instr_done, 1'b1);
        run = 1'b0;
        tick();
        for (int c = 5; c <= 8; c++) begin
            chk("hold_pc", prog_addr, 12'h002);
            chk("hold_done", instr_done, 1'b0);
            if (c != 8) tick();
        end
        chk("hold_acc", alu_a, 4'h5);
        run = 1'b1;
        tick();
        chk("out_strobe", out_strobe, 1'b1);
        chk("out_data_pre", out_data, 4'h0);
        tick();
        chk("out_data", out_data, 4'h5);
        chk("out_strobe_off", out_strobe, 1'b0);
        tick(); tick();
        chk("in_acc", alu_a, 4'h6);
        chk("in_flags", {flag_c_n, flag_z_n}, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
